// File: rtl/seq_twos_multiplier_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM encoding and
// the counter width helper.
package seq_twos_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_SIGN = 2'd2
    } mult_state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must be able to hold the value WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int DEFAULT_CNT_W = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/seq_twos_multiplier_twos_comp_n.sv
// Combinational two's complement negator of parametrised width N.
module twos_comp_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] OPERAND,
    output logic [N-1:0] RESULT
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    assign RESULT = ~OPERAND + ONE;

endmodule

// File: rtl/seq_twos_multiplier.sv
// Iterative shift-add multiplier, signed/unsigned per operation, START/BUSY/DONE
// handshake. Define MULT_EARLY_EXIT_EN to finish as soon as the multiplier drains.
module seq_twos_multiplier
    import seq_twos_multiplier_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 START,
    input  logic                 SIGNED_MODE,
    input  logic [WIDTH-1:0]     OPERAND_A,
    input  logic [WIDTH-1:0]     OPERAND_B,
    output logic                 BUSY,
    output logic                 DONE,
    output logic [2*WIDTH-1:0]   RESULT
);

    localparam int CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    mult_state_e          state_q, state_d;
    logic [2*WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 sign_q, sign_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 done_q, done_d;

    logic signed [WIDTH-1:0] a_s, b_s;
    logic [WIDTH-1:0]     neg_a, neg_b, mag_a, mag_b;
    logic [2*WIDTH-1:0]   neg_acc;

    twos_comp_n #(.N(WIDTH)) u_neg_a (
        .OPERAND (OPERAND_A),
        .RESULT  (neg_a)
    );

    twos_comp_n #(.N(WIDTH)) u_neg_b (
        .OPERAND (OPERAND_B),
        .RESULT  (neg_b)
    );

    twos_comp_n #(.N(2*WIDTH)) u_neg_acc (
        .OPERAND (acc_q),
        .RESULT  (neg_acc)
    );

    // Negating the most-negative value wraps to 2^(WIDTH-1), which is exactly
    // the correct unsigned magnitude.
    assign a_s   = OPERAND_A;
    assign b_s   = OPERAND_B;
    assign mag_a = (SIGNED_MODE && (a_s < 0)) ? neg_a : OPERAND_A;
    assign mag_b = (SIGNED_MODE && (b_s < 0)) ? neg_b : OPERAND_B;

    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (START) begin
                    mcand_d  = {{WIDTH{1'b0}}, mag_a};
                    mplier_d = mag_b;
                    sign_d   = SIGNED_MODE & (OPERAND_A[WIDTH-1] ^ OPERAND_B[WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = ST_CALC;
                end
            end
            ST_CALC: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CNT_ONE;
                if (cnt_d == CNT_LAST) begin
                    state_d = ST_SIGN;
                end
`ifdef MULT_EARLY_EXIT_EN
                if (mplier_d == '0) begin
                    state_d = ST_SIGN;
                end
`endif
            end
            ST_SIGN: begin
                result_d = sign_q ? neg_acc : acc_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= ST_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign BUSY   = (state_q != ST_IDLE);
    assign DONE   = done_q;
    assign RESULT = result_q;

endmodule

// File: tb/tb_seq_twos_multiplier.sv
// Directed self-checking bench for seq_twos_multiplier at WIDTH=8; expected
// latencies follow MULT_EARLY_EXIT_EN when it is defined.
module tb_seq_twos_multiplier;

    localparam int W = 8;
`ifdef MULT_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic            sm = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seq_twos_multiplier #(.WIDTH(W)) dut (
        .CLK         (clk),
        .RESET       (rst),
        .START       (start),
        .SIGNED_MODE (sm),
        .OPERAND_A   (a),
        .OPERAND_B   (b),
        .BUSY        (busy),
        .DONE        (done),
        .RESULT      (result)
    );

    typedef struct {
        logic          m;
        logic [7:0]    xa;
        logic [7:0]    xb;
        logic [15:0]   r;
        int            e_early;
    } vec_t;

    // mode, A, B, product, edges to DONE with early exit (fixed build: 9)
    vec_t vecs [0:10] = '{
        '{1'b1, 8'h07, 8'hFD, 16'hFFEB, 3},
        '{1'b1, 8'h80, 8'h80, 16'h4000, 9},
        '{1'b0, 8'hFF, 8'hFF, 16'hFE01, 9},
        '{1'b1, 8'hFF, 8'hFF, 16'h0001, 2},
        '{1'b1, 8'h00, 8'h80, 16'h0000, 9},
        '{1'b1, 8'h80, 8'h01, 16'hFF80, 2},
        '{1'b1, 8'h7F, 8'h7F, 16'h3F01, 8},
        '{1'b0, 8'h80, 8'h02, 16'h0100, 3},
        '{1'b0, 8'h05, 8'h01, 16'h0005, 2},
        '{1'b0, 8'h05, 8'h00, 16'h0000, 2},
        '{1'b0, 8'h01, 8'h80, 16'h0080, 9}
    };

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one operation and wait (bounded) for DONE; edges = -1 on timeout.
    task automatic do_op(input logic m, input logic [7:0] xa, input logic [7:0] xb,
                         output int edges, output logic [15:0] res, output logic bsy);
        sm    = m;
        a     = xa;
        b     = xb;
        start = 1'b1;
        tick();
        start = 1'b0;
        edges = -1;
        res   = 'x;
        bsy   = 1'bx;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                edges = i;
                res   = result;
                bsy   = busy;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        tick();
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", done);
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL reset_result got %h want 0000", result);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_vectors();
        int          edges;
        int          exp_edges;
        logic [15:0] res;
        logic        bsy;
        for (int v = 0; v < 11; v++) begin
            do_op(vecs[v].m, vecs[v].xa, vecs[v].xb, edges, res, bsy);
            exp_edges = EARLY ? vecs[v].e_early : 9;
            checks++;
            if (res !== vecs[v].r) begin
                errors++;
                $display("FAIL vec%0d_result got %h want %h", v, res, vecs[v].r);
            end
            checks++;
            if (edges != exp_edges) begin
                errors++;
                $display("FAIL vec%0d_latency got %0d want %0d", v, edges, exp_edges);
            end
            checks++;
            if (bsy !== 1'b0) begin
                errors++;
                $display("FAIL vec%0d_busy_at_done got %b want 0", v, bsy);
            end
        end
    endtask

    task automatic test_start_ignored();
        int          edges;
        int          extra;
        int          exp_edges;
        logic [15:0] res;
        exp_edges = EARLY ? 4 : 9;
        sm    = 1'b0;
        a     = 8'd3;
        b     = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_after_start got %b want 1", busy);
        end
        tick();
        a     = 8'd9;
        b     = 8'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 8'd0;
        b     = 8'd0;
        edges = -1;
        res   = 'x;
        for (int i = 3; i <= 40; i++) begin
            tick();
            if (done === 1'b1) begin
                edges = i;
                res   = result;
                break;
            end
        end
        checks++;
        if (edges != exp_edges) begin
            errors++;
            $display("FAIL ignored_latency got %0d want %0d", edges, exp_edges);
        end
        checks++;
        if (res !== 16'h000F) begin
            errors++;
            $display("FAIL ignored_result got %h want 000F", res);
        end
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL ignored_extra_done got %0d want 0", extra);
        end
        checks++;
        if (result !== 16'h000F) begin
            errors++;
            $display("FAIL ignored_result_hold got %h want 000F", result);
        end
    endtask

    task automatic test_back_to_back();
        int          edges;
        int          exp_edges;
        logic [15:0] res;
        logic        bsy;
        exp_edges = EARLY ? 2 : 9;
        do_op(1'b1, 8'h07, 8'hFD, edges, res, bsy);
        checks++;
        if (res !== 16'hFFEB) begin
            errors++;
            $display("FAIL b2b_first_result got %h want FFEB", res);
        end
        // Still in the DONE cycle here, so this START must be accepted.
        do_op(1'b1, 8'h02, 8'hFF, edges, res, bsy);
        checks++;
        if (edges != exp_edges) begin
            errors++;
            $display("FAIL b2b_latency got %0d want %0d", edges, exp_edges);
        end
        checks++;
        if (res !== 16'hFFFE) begin
            errors++;
            $display("FAIL b2b_result got %h want FFFE", res);
        end
        tick();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_done_pulse got %b want 0", done);
        end
    endtask

    task automatic test_reset_mid();
        int          edges;
        int          extra;
        int          exp_edges;
        logic [15:0] res;
        logic        bsy;
        exp_edges = EARLY ? 4 : 9;
        sm    = 1'b0;
        a     = 8'd3;
        b     = 8'h85;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_busy got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midrst_done got %b want 0", done);
        end
        checks++;
        if (result !== 16'h0000) begin
            errors++;
            $display("FAIL midrst_result got %h want 0000", result);
        end
        rst   = 1'b0;
        extra = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL midrst_spurious_done got %0d want 0", extra);
        end
        do_op(1'b0, 8'd3, 8'd5, edges, res, bsy);
        checks++;
        if (res !== 16'h000F) begin
            errors++;
            $display("FAIL midrst_restart_result got %h want 000F", res);
        end
        checks++;
        if (edges != exp_edges) begin
            errors++;
            $display("FAIL midrst_restart_latency got %0d want %0d", edges, exp_edges);
        end
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_twos_multiplier.md
Name: seq_twos_multiplier

Overview:
- Iterative shift-add multiplier for the ALU datapath, parametrised in operand width.
- Signed (two's complement) and unsigned modes, selected per operation.
- Signed operands are converted to magnitudes, multiplied unsigned, then the sign is re-applied with a parametrised two's complement negator.
- Start/busy/done handshake so the control unit can stall the single-cycle pipeline while it waits for a result.

Parameters:
- WIDTH, 8, operand width in bits (must be ≥ 2); RESULT is 2*WIDTH bits.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge
- RESET  input  1  synchronous, active-high reset
- START  input  1  request; sampled only while idle
- SIGNED_MODE  input  1  1 = operands are two's complement, 0 = unsigned; sampled with START
- OPERAND_A  input  WIDTH  multiplicand; sampled with START
- OPERAND_B  input  WIDTH  multiplier; sampled with START
- BUSY  output  1  high while an operation is in flight
- DONE  output  1  one-cycle pulse when RESULT is updated
- RESULT  output  2*WIDTH  product; holds its value until the next completion

Behaviour:
- Reset (synchronous, active-high; takes priority over everything):
  - state=IDLE, BUSY=0, DONE=0, RESULT=0, internal registers cleared.
  - Asserting RESET mid-operation aborts the operation; no DONE is produced.
- States: IDLE, CALC, SIGN.
- IDLE:
  - If START=1 at edge k, register |A|, |B|, the sign flag and SIGNED_MODE; clear the accumulator and cycle counter; go to CALC. BUSY=1 from edge k.
  - Magnitude of a WIDTH-bit signed operand is its two's complement negation when MSB=1 and SIGNED_MODE=1; otherwise the raw bits, zero-extended.
  - Sign flag = A[MSB] XOR B[MSB] when SIGNED_MODE=1, else 0.
- CALC, once per edge:
  - If mplier[0]=1, add mcand to the 2*WIDTH accumulator.
  - Shift mcand left 1 and mplier right 1; increment the counter.
  - After WIDTH steps (counter == WIDTH), go to SIGN.
- SIGN, at edge k+WIDTH+1:
  - RESULT <= sign ? two's complement of the accumulator : accumulator.
  - DONE=1 for exactly one cycle; BUSY=0; go to IDLE.
  - Latency without the optional feature is fixed: DONE is high in the cycle after edge k+WIDTH+1.
- START while BUSY=1 is ignored; operands are not resampled.
- START asserted during the DONE cycle (state IDLE) is accepted, so operations can run back to back.
- Arithmetic widths and boundaries:
  - Accumulator and mcand are 2*WIDTH bits; no overflow is possible.
  - Most-negative operand −2^(WIDTH−1) has magnitude 2^(WIDTH−1), which fits in WIDTH unsigned bits.
  - (−2^(WIDTH−1))² = 2^(2WIDTH−2) is representable in the result.
  - A zero product with sign=1 still yields 0, since negating 0 gives 0.
- RESULT changes only on the SIGN edge or on reset.

Optional Feature:
- Macro: MULT_EARLY_EXIT_EN.
- Defined: in CALC, the block also goes to SIGN when the post-step mplier == 0.
  - CALC edges = h+1, where h = index of the highest set bit of |B| (h=0 when B=0).
  - DONE is high in the cycle after edge k+h+2.
  - Result values are identical to the fixed-latency build.
- Undefined: fixed latency of WIDTH CALC cycles; the zero-detect logic is not synthesised.

Decomposition:
- Shared package: state encoding constants (IDLE, CALC, SIGN) and the counter width localparam, clog2(WIDTH+1).
- One sub-module: twos_comp_n
  - Parametrised combinational negator, RESULT = ~OPERAND + 1, width parameter N.
  - Instantiated twice at N=WIDTH for the operand magnitudes and once at N=2*WIDTH for the sign fix.

Test Plan (WIDTH=8):
- Signed negative product: START, SIGNED_MODE=1, A=0x07, B=0xFD -> DONE high exactly 9 edges after the START edge, RESULT=0xFFEB (−21), BUSY low in the DONE cycle.
- Most-negative operands: SIGNED_MODE=1, A=0x80, B=0x80 -> RESULT=0x4000. Unsigned max: SIGNED_MODE=0, A=0xFF, B=0xFF -> RESULT=0xFE01.
- Start ignored while busy: START with A=3, B=5, then START with A=9, B=9 two cycles later -> single DONE, RESULT=0x000F; RESULT holds afterwards.
- Back-to-back: START asserted in the DONE cycle with A=2, B=0xFF signed -> second DONE 9 edges later, RESULT=0xFFFE.
- Reset mid-operation: RESET asserted 4 cycles into CALC -> next cycle BUSY=0, DONE=0, RESULT=0; no DONE follows; a new START completes normally.
- Early exit (MULT_EARLY_EXIT_EN defined): A=0x05, B=0x01 -> DONE after 2 edges, RESULT=0x0005; B=0x00 -> RESULT=0 after 2 edges; A=1, B=0x80 unsigned -> 9 edges, RESULT=0x0080.
